// File: rtl/fmps_test_link_checker_if.sv
// -----------------------------------------------------------------------------
// fmps_test_link_checker_if
// AXI-Stream bundle that carries the dummy FMPS test stream.
//   tdata  [31:0] : stream word (header or data)
//   tvalid        : word valid
//   tlast         : 0 on a header word, 1 on a data word
//   tready        : consumer ready
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
// -----------------------------------------------------------------------------
interface fmps_test_link_checker_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fmps_test_link_checker.sv
// -----------------------------------------------------------------------------
// fmps_test_link_checker
// Checks header/data packet pairs of the FMPS test stream in the Aurora user
// clock domain. It reports one status strobe per FA session and keeps packet
// and error counters for CSR readback.
//
// Ports:
//   auroraUserClk            : clock
//   auroraReset              : synchronous active-high reset
//   auroraFAstrobe           : session start pulse; samples the two exp* inputs
//   expFmpsIndexBase [4:0]   : index expected on the first header of a session
//   expPacketCount   [5:0]   : packets per session (0 treated as 1)
//   FMPS_TEST_AXI_STREAM_RX  : stream input (slave modport)
//   CHECKstatusStrobe        : one-cycle end-of-session pulse
//   CHECKstatusCode  [1:0]   : 0 OK, 1 format, 2 sequence, 3 short/extra
//   packetCount      [5:0]   : packets received in the current session
//   errorCount               : saturating count of erroneous words
//   lastFAcycle      [7:0]   : FA cycle of the most recent fault-free data word
//   dbgState         [2:0]   : state encoding
//
// Build option: FMPS_TEST_CHECK_BACKPRESSURE_EN drives tready from a 16-bit
// LFSR (about 25% stall cycles); otherwise tready is 1 outside reset.
// -----------------------------------------------------------------------------
module fmps_test_link_checker #(
  parameter  int MAX_FMPSS       = 32,
  parameter  int ERR_COUNT_WIDTH = 16,
  localparam int IDX_W           = $clog2(MAX_FMPSS)
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraReset,
  input  logic                       auroraFAstrobe,
  input  logic [IDX_W-1:0]           expFmpsIndexBase,
  input  logic [IDX_W:0]             expPacketCount,
  fmps_test_link_checker_if.slave    FMPS_TEST_AXI_STREAM_RX,
  output logic                       CHECKstatusStrobe,
  output logic [1:0]                 CHECKstatusCode,
  output logic [IDX_W:0]             packetCount,
  output logic [ERR_COUNT_WIDTH-1:0] errorCount,
  output logic [7:0]                 lastFAcycle,
  output logic [2:0]                 dbgState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HDR  = 3'd1,
    WAIT_DATA = 3'd2,
    DONE      = 3'd3
  } state_e;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_FMPSS);
  localparam logic [1:0] CODE_FMT = 2'd1;
  localparam logic [1:0] CODE_SEQ = 2'd2;
  localparam logic [1:0] CODE_CNT = 2'd3;

  function automatic logic [1:0] max_code(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           base_q, base_d;
  logic [IDX_W:0]             exp_cnt_q, exp_cnt_d;
  logic [IDX_W-1:0]           pkt_idx_q, pkt_idx_d;
  logic [IDX_W:0]             pkt_cnt_q, pkt_cnt_d;
  logic [1:0]                 sticky_q, sticky_d;
  logic                       pend_q, pend_d;        // extra word seen in DONE
  logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]                 last_fa_q, last_fa_d;
  logic [7:0]                 first_fa_q, first_fa_d;
  logic                       first_fa_vld_q, first_fa_vld_d;
  logic                       strobe_q, strobe_d;
  logic [1:0]                 code_q, code_d;
  logic                       tready_q, tready_d;

  logic [31:0]      tdata;
  logic             accept;
  logic [IDX_W-1:0] exp_idx;
  logic             hdr_fmt_err, hdr_seq_err, dat_fmt_err, dat_seq_err;
  logic [1:0]       hdr_code, dat_code, word_code;
  logic             word_bad;
  logic [IDX_W:0]   exp_cnt_in;

  assign tdata  = FMPS_TEST_AXI_STREAM_RX.tdata;
  assign accept = FMPS_TEST_AXI_STREAM_RX.tvalid & tready_q;

  // Header: B6CF | enable | index | ten zero bits; tlast must be low.
  assign exp_idx     = base_q + pkt_idx_q;  // wraps modulo MAX_FMPSS
  assign hdr_fmt_err = (tdata[31:16] != 16'hB6CF) | ~tdata[15] | (tdata[9:0] != 10'd0)
                     | FMPS_TEST_AXI_STREAM_RX.tlast;
  assign hdr_seq_err = (tdata[14:10] != exp_idx);
  assign hdr_code    = hdr_seq_err ? CODE_SEQ : (hdr_fmt_err ? CODE_FMT : 2'd0);

  // Data: zero bits | counter | CACA | FA cycle; tlast must be high. The FA
  // cycle is compared only once the session's first data word has set it.
  assign dat_fmt_err = ~FMPS_TEST_AXI_STREAM_RX.tlast | (tdata[31:29] != 3'd0)
                     | (tdata[23:8] != 16'hCACA);
  assign dat_seq_err = (tdata[28:24] != pkt_idx_q)
                     | (first_fa_vld_q & (tdata[7:0] != first_fa_q));
  assign dat_code    = dat_seq_err ? CODE_SEQ : (dat_fmt_err ? CODE_FMT : 2'd0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    exp_cnt_d      = exp_cnt_q;
    pkt_idx_d      = pkt_idx_q;
    pkt_cnt_d      = pkt_cnt_q;
    sticky_d       = sticky_q;
    pend_d         = pend_q;
    err_cnt_d      = err_cnt_q;
    last_fa_d      = last_fa_q;
    first_fa_d     = first_fa_q;
    first_fa_vld_d = first_fa_vld_q;
    strobe_d       = 1'b0;
    code_d         = 2'd0;
    word_code      = 2'd0;
    word_bad       = 1'b0;

    exp_cnt_in = expPacketCount;
    if (expPacketCount == '0)          exp_cnt_in = (IDX_W+1)'(1);
    else if (expPacketCount > MAX_CNT) exp_cnt_in = MAX_CNT;

    // Word processing first: a word accepted together with auroraFAstrobe
    // still belongs to the old session.
    if (accept) begin
      unique case (state_q)
        WAIT_HDR: begin
          word_code = hdr_code;
          word_bad  = (hdr_code != 2'd0);
          sticky_d  = max_code(sticky_q, hdr_code);
          state_d   = WAIT_DATA;
        end
        WAIT_DATA: begin
          word_code = dat_code;
          word_bad  = (dat_code != 2'd0);
          sticky_d  = max_code(sticky_q, dat_code);
          pkt_idx_d = pkt_idx_q + 1'b1;
          pkt_cnt_d = pkt_cnt_q + 1'b1;
          if (!first_fa_vld_q) begin
            first_fa_vld_d = 1'b1;
            first_fa_d     = tdata[7:0];
          end
          if (dat_code == 2'd0) last_fa_d = tdata[7:0];
          if (pkt_cnt_d == exp_cnt_q) begin
            strobe_d = 1'b1;
            code_d   = sticky_d;
            state_d  = DONE;
          end else begin
            state_d = WAIT_HDR;
          end
        end
        DONE: begin
          word_bad = 1'b1;
          pend_d   = 1'b1;
        end
        default: ;  // IDLE discards words silently
      endcase
    end

    if (word_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;

    if (auroraFAstrobe) begin
      // A completion strobe in the same cycle takes precedence; otherwise an
      // unfinished session or a pending extra-word code is reported as 3.
      if (!strobe_d && ((state_q == WAIT_HDR) || (state_q == WAIT_DATA) || pend_d)) begin
        strobe_d = 1'b1;
        code_d   = CODE_CNT;
      end
      base_d         = expFmpsIndexBase;
      exp_cnt_d      = exp_cnt_in;
      pkt_idx_d      = '0;
      pkt_cnt_d      = '0;
      sticky_d       = 2'd0;
      pend_d         = 1'b0;
      first_fa_vld_d = 1'b0;
      state_d        = WAIT_HDR;
    end
  end

`ifdef FMPS_TEST_CHECK_BACKPRESSURE_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; stall whenever the low two bits are 0.
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign tready_d = (lfsr_d[1:0] != 2'b00);

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) lfsr_q <= 16'hACE1;
    else             lfsr_q <= lfsr_d;
  end
`else
  assign tready_d = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge auroraUserClk) begin
    // NOTE: every flop is reset, including session context, so a reset in
    // mid-packet leaves nothing stale for the next session.
    if (auroraReset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      exp_cnt_q      <= '0;
      pkt_idx_q      <= '0;
      pkt_cnt_q      <= '0;
      sticky_q       <= 2'd0;
      pend_q         <= 1'b0;
      err_cnt_q      <= '0;
      last_fa_q      <= 8'd0;
      first_fa_q     <= 8'd0;
      first_fa_vld_q <= 1'b0;
      strobe_q       <= 1'b0;
      code_q         <= 2'd0;
      tready_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      exp_cnt_q      <= exp_cnt_d;
      pkt_idx_q      <= pkt_idx_d;
      pkt_cnt_q      <= pkt_cnt_d;
      sticky_q       <= sticky_d;
      pend_q         <= pend_d;
      err_cnt_q      <= err_cnt_d;
      last_fa_q      <= last_fa_d;
      first_fa_q     <= first_fa_d;
      first_fa_vld_q <= first_fa_vld_d;
      strobe_q       <= strobe_d;
      code_q         <= code_d;
      tready_q       <= tready_d;
    end
  end

  assign FMPS_TEST_AXI_STREAM_RX.tready = tready_q;
  assign CHECKstatusStrobe = strobe_q;
  assign CHECKstatusCode   = code_q;
  assign packetCount       = pkt_cnt_q;
  assign errorCount        = err_cnt_q;
  assign lastFAcycle       = last_fa_q;
  assign dbgState          = state_q;

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// -----------------------------------------------------------------------------
// tb_fmps_test_link_checker
// Directed bench for fmps_test_link_checker: reset, good session, bad magic,
// index wrap (good and bad), short session, extra words in DONE, strobe
// collision and reset in mid-packet. Works with or without the backpressure
// build option since every word waits for tready.
// -----------------------------------------------------------------------------
module tb_fmps_test_link_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fa  = 1'b0;
  logic [4:0]  base = 5'd0;
  logic [5:0]  cnt  = 6'd0;
  logic        strobe;
  logic [1:0]  code;
  logic [5:0]  pkt_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  last_fa;
  logic [2:0]  dbg;

  int n_vec = 0;
  int n_mis = 0;

  fmps_test_link_checker_if axis ();

  fmps_test_link_checker dut (
    .auroraUserClk           (clk),
    .auroraReset             (rst),
    .auroraFAstrobe          (fa),
    .expFmpsIndexBase        (base),
    .expPacketCount          (cnt),
    .FMPS_TEST_AXI_STREAM_RX (axis),
    .CHECKstatusStrobe       (strobe),
    .CHECKstatusCode         (code),
    .packetCount             (pkt_cnt),
    .errorCount              (err_cnt),
    .lastFAcycle             (last_fa),
    .dbgState                (dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
      else begin
        n_mis++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [31:0] hdr(input logic [4:0] idx);
    return {16'hB6CF, 1'b1, idx, 10'd0};
  endfunction

  function automatic logic [31:0] dat(input logic [4:0] ctr, input logic [7:0] fac);
    return {3'b000, ctr, 16'hCACA, fac};
  endfunction

  // Presents one word and waits (bounded) for the accepting edge; optionally
  // raises auroraFAstrobe on exactly that edge. Returns #1 after the edge.
  task automatic send(input logic [31:0] data, input logic last, input logic with_fa);
    logic got;
    got = 1'b0;
    axis.tdata  = data;
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      if (axis.tready) begin
        fa  = with_fa;
        got = 1'b1;
      end
      tick();
    end
    fa          = 1'b0;
    axis.tvalid = 1'b0;
    check("accept", {31'd0, got}, 32'd1);
  endtask

  task automatic pair(input logic [4:0] idx, input logic [4:0] ctr, input logic [7:0] fac);
    send(hdr(idx), 1'b0, 1'b0);
    send(dat(ctr, fac), 1'b1, 1'b0);
  endtask

  task automatic fa_pulse(input logic [4:0] b, input logic [5:0] c);
    base = b;
    cnt  = c;
    fa   = 1'b1;
    tick();
    fa   = 1'b0;
  endtask

  task automatic good_session();
    logic [4:0] i5;
    fa_pulse(5'd3, 6'd4);
    check("good_start_state", dbg, 3'd1);
    check("good_start_strobe", strobe, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i5 = 5'(i);
      pair(5'd3 + i5, i5, 8'h05);
      if (i < 3) begin
        check("good_mid_strobe", strobe, 1'b0);
        check("good_mid_pkt", pkt_cnt, 6'(i + 1));
      end
    end
    check("good_strobe", strobe, 1'b1);
    check("good_code", code, 2'd0);
    check("good_pkt", pkt_cnt, 6'd4);
    check("good_err", err_cnt, 16'd0);
    check("good_lastfa", last_fa, 8'h05);
    check("good_state", dbg, 3'd3);
    tick();
    check("good_strobe_pulse", strobe, 1'b0);
  endtask

  initial begin
    axis.tdata  = 32'd0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_state", dbg, 3'd0);
    check("rst_tready", axis.tready, 1'b0);
    check("rst_strobe", strobe, 1'b0);
    check("rst_code", code, 2'd0);
    check("rst_pkt", pkt_cnt, 6'd0);
    check("rst_err", err_cnt, 16'd0);
    check("rst_lastfa", last_fa, 8'd0);
    rst = 1'b0;
    tick();
    check("post_rst_tready", axis.tready, 1'b1);
    check("post_rst_state", dbg, 3'd0);

    // IDLE discards words silently
    send(32'hDEADBEEF, 1'b1, 1'b0);
    check("idle_err", err_cnt, 16'd0);
    check("idle_strobe", strobe, 1'b0);
    check("idle_state", dbg, 3'd0);

    good_session();

    // Bad magic on the first header
    fa_pulse(5'd0, 6'd2);
    check("magic_start_strobe", strobe, 1'b0);
    check("magic_start_pkt", pkt_cnt, 6'd0);
    send({16'hB6CE, 1'b1, 5'd0, 10'd0}, 1'b0, 1'b0);
    send(dat(5'd0, 8'h07), 1'b1, 1'b0);
    check("magic_mid_strobe", strobe, 1'b0);
    check("magic_mid_err", err_cnt, 16'd1);
    pair(5'd1, 5'd1, 8'h07);
    check("magic_strobe", strobe, 1'b1);
    check("magic_code", code, 2'd1);
    check("magic_err", err_cnt, 16'd1);
    check("magic_lastfa", last_fa, 8'h07);

    // Index wrap, correct indices 31,0,1 with a stall gap before one data word
    fa_pulse(5'd31, 6'd3);
    pair(5'd31, 5'd0, 8'h09);
    send(hdr(5'd0), 1'b0, 1'b0);
    repeat (3) tick();
    check("wrap_gap_state", dbg, 3'd2);
    send(dat(5'd1, 8'h09), 1'b1, 1'b0);
    pair(5'd1, 5'd2, 8'h09);
    check("wrap_ok_strobe", strobe, 1'b1);
    check("wrap_ok_code", code, 2'd0);
    check("wrap_ok_pkt", pkt_cnt, 6'd3);
    check("wrap_ok_err", err_cnt, 16'd1);

    // Index wrap, wrong indices 31,1,2
    fa_pulse(5'd31, 6'd3);
    pair(5'd31, 5'd0, 8'h09);
    pair(5'd1, 5'd1, 8'h09);
    pair(5'd2, 5'd2, 8'h09);
    check("wrap_bad_strobe", strobe, 1'b1);
    check("wrap_bad_code", code, 2'd2);
    check("wrap_bad_err", err_cnt, 16'd3);

    // Short session: 2 of 4 packets, then a new FA strobe
    fa_pulse(5'd0, 6'd4);
    pair(5'd0, 5'd0, 8'h11);
    pair(5'd1, 5'd1, 8'h11);
    check("short_mid_pkt", pkt_cnt, 6'd2);
    check("short_mid_strobe", strobe, 1'b0);
    fa_pulse(5'd0, 6'd1);
    check("short_strobe", strobe, 1'b1);
    check("short_code", code, 2'd3);
    check("short_pkt", pkt_cnt, 6'd0);
    check("short_state", dbg, 3'd1);
    check("short_err", err_cnt, 16'd3);
    tick();
    check("short_strobe_pulse", strobe, 1'b0);

    // Extra words after completion (session of 1 loaded above)
    pair(5'd0, 5'd0, 8'h22);
    check("extra_first_strobe", strobe, 1'b1);
    check("extra_first_code", code, 2'd0);
    check("extra_first_pkt", pkt_cnt, 6'd1);
    check("extra_lastfa", last_fa, 8'h22);
    pair(5'd1, 5'd1, 8'h22);
    check("extra_no_strobe", strobe, 1'b0);
    check("extra_err", err_cnt, 16'd5);
    check("extra_state", dbg, 3'd3);
    fa_pulse(5'd0, 6'd2);
    check("extra_fa_strobe", strobe, 1'b1);
    check("extra_fa_code", code, 2'd3);
    check("extra_fa_pkt", pkt_cnt, 6'd0);

    // FA strobe coincides with the final data word
    pair(5'd0, 5'd0, 8'h33);
    send(hdr(5'd1), 1'b0, 1'b0);
    base = 5'd5;
    cnt  = 6'd2;
    send(dat(5'd1, 8'h33), 1'b1, 1'b1);
    check("coll_strobe", strobe, 1'b1);
    check("coll_code", code, 2'd0);
    check("coll_pkt", pkt_cnt, 6'd0);
    check("coll_state", dbg, 3'd1);
    check("coll_lastfa", last_fa, 8'h33);
    check("coll_err", err_cnt, 16'd5);
    tick();
    check("coll_single_strobe", strobe, 1'b0);

    // Reset while waiting for the data word of the new session
    send(hdr(5'd5), 1'b0, 1'b0);
    check("midrst_pre_state", dbg, 3'd2);
    check("midrst_pre_err", err_cnt, 16'd5);
    rst = 1'b1;
    tick();
    check("midrst_state", dbg, 3'd0);
    check("midrst_tready", axis.tready, 1'b0);
    check("midrst_strobe", strobe, 1'b0);
    check("midrst_pkt", pkt_cnt, 6'd0);
    check("midrst_err", err_cnt, 16'd0);
    check("midrst_lastfa", last_fa, 8'd0);
    rst = 1'b0;
    tick();

    good_session();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fmps_test_link_checker.md
# fmps_test_link_checker

Downstream consumer of the dummy FMPS test stream in the Aurora user clock domain. It accepts header/data packet pairs from the FMPS test AXI-Stream and checks framing, magic values, FMPS index sequence, data counter and FA cycle number. At the end of each FA session it reports one status strobe with a code, and it keeps running packet and error counters for the CSR readback path.

## Interface
- `MAX_FMPSS`, 32: maximum packets per session. Index width is `$clog2(MAX_FMPSS)`, which is 5.
- `ERR_COUNT_WIDTH`, 16: width of the saturating error counter.
- `auroraUserClk` in 1: the single clock.
- `auroraReset` in 1: synchronous, active-high reset.
- `auroraFAstrobe` in 1: session start marker, one-cycle pulse.
- `expFmpsIndexBase` in 5: expected index of the first packet in a session. Sampled on `auroraFAstrobe`.
- `expPacketCount` in 6: packets per session, 1..32. A value of 0 is treated as 1. Sampled on `auroraFAstrobe`.
- `FMPS_TEST_AXI_STREAM_RX_tdata` in 32: stream data.
- `FMPS_TEST_AXI_STREAM_RX_tvalid` in 1: stream valid.
- `FMPS_TEST_AXI_STREAM_RX_tlast` in 1: stream last. Must be 0 on a header word and 1 on a data word.
- `FMPS_TEST_AXI_STREAM_RX_tready` out 1: stream ready.
- `CHECKstatusStrobe` out 1: one-cycle pulse at the end of a session.
- `CHECKstatusCode` out 2: session result, valid while the strobe is high.
  - 0 = OK
  - 1 = format error
  - 2 = sequence error
  - 3 = short or extra packets
- `packetCount` out 6: packets received in the current session.
- `errorCount` out `ERR_COUNT_WIDTH`: total erroneous words since reset. Saturates at all ones.
- `lastFAcycle` out 8: FA cycle field of the most recent good data word.
- `dbgState` out 3: current state encoding.

## Operation
- **Word acceptance:** a word is accepted on any cycle where tvalid and tready are both high.
- **Header format:** [31:16] = 16'hB6CF, [15] = 1, [14:10] = FMPS index, [9:0] = 0.
- **Data format:** [31:29] = 0, [28:24] = data counter, [23:8] = 16'hCACA, [7:0] = FA cycle.
- **States:** IDLE=0, WAIT_HDR=1, WAIT_DATA=2, DONE=3.
- **`auroraFAstrobe` in any state:**
  - If the previous session is in WAIT_HDR or WAIT_DATA, emit a strobe with code 3, or the sticky error code if that is higher.
  - Then load the expected values, clear `pktIdx`, clear `packetCount` and the sticky code, and enter WAIT_HDR.
- **WAIT_HDR, on accept:**
  - Format error (code 1) if the magic, enable bit or zero bits are wrong, or if tlast is 1.
  - Sequence error (code 2) if the index ≠ (base + `pktIdx`) mod 32.
  - Always go to WAIT_DATA.
- **WAIT_DATA, on accept:**
  - Format error if tlast is 0, [31:29] ≠ 0, or [23:8] ≠ CACA.
  - Sequence error if the data counter ≠ `pktIdx`, or if the FA cycle ≠ the FA cycle of the session's first data word.
  - Increment `pktIdx` and `packetCount`.
  - If `packetCount` now equals the expected count, emit the strobe with the sticky code and go to DONE. Otherwise go back to WAIT_HDR.
- **Sticky code:** holds the maximum of all codes seen in the session, so 1 < 2 < 3 in priority.
- **errorCount:** increments by 1 per erroneous word. A word with several faults counts once.
- **DONE:** any accepted word increments `errorCount` and sets the pending code to 3. That code is reported by the strobe issued on the next `auroraFAstrobe`.
- **IDLE:** accepted words are discarded silently.
- **lastFAcycle:** updated only from data words with no fault.

## Timing
- **Reset values:**
  - state = IDLE
  - tready = 0 during reset, 1 from the first cycle after reset
  - all outputs 0
- **Status latency:** `CHECKstatusStrobe` and `CHECKstatusCode` are registered. They assert one cycle after the accepting edge of the last data word, or one cycle after the `auroraFAstrobe` edge.
- **Counter latency:** counters update one cycle after the accept.
- **Strobe collision:** if `auroraFAstrobe` coincides with the accept of the final data word, the strobe is issued once, with the completion result. The new session's counters start from 0, and that word counts toward the old session.
- **Strobe during reset:** `auroraReset` has priority over `auroraFAstrobe`. No strobe is issued while in reset.
- **Wrap-around:** index arithmetic wraps modulo 32, and `packetCount` never exceeds 32.
- **Stalls:** a back-to-back stream at 1 word per cycle must be sustained. A tvalid low gap of any length between the header and data words is legal.

## Configuration
- **`FMPS_TEST_CHECK_BACKPRESSURE_EN` defined:**
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) drives tready.
  - tready = 0 whenever LFSR[1:0] == 2'b00, giving about 25% stall cycles. This exercises the upstream FIFO and the almost-full throttling.
- **Not defined:** tready is constantly 1 outside reset, and no LFSR logic is present.

## Test plan
- **Good session:** base=3, count=4, then 4 correct pairs with FA cycle 8'h05 and counters 0..3 → one strobe, code 0, `packetCount`=4, `errorCount`=0, `lastFAcycle`=8'h05.
- **Bad magic:** header 16'hB6CE → strobe code 1 at completion, `errorCount`=1.
- **Index wrap:** base=31, count=3, indices 31, 0, 1 → code 0. Indices 31, 1, 2 → code 2.
- **Short session:** count=4, only 2 pairs sent, then `auroraFAstrobe` → strobe code 3 on the cycle after the strobe edge, and `packetCount` resets to 0.
- **Extra word in DONE:** count=1, 2 pairs sent → first strobe code 0, `errorCount`=2, next `auroraFAstrobe` gives a strobe with code 3.
- **Reset mid-packet:** assert `auroraReset` in WAIT_DATA → next cycle state = IDLE, tready = 0, all counters 0, no strobe. With `FMPS_TEST_CHECK_BACKPRESSURE_EN`, repeat the good session and get an identical result.
